// File: rtl/reg_file.sv
// reg_file: multi-ported register file, one write port and two combinational read ports.
// Register 0 is hard-wired to zero and has no storage behind it.
//
// Parameters: WIDTH (data bits, 1..64), DEPTH (registers, 2..256), AW (derived address width).
// Ports:
//   clk    - clock, writes on rising edge
//   reset  - asynchronous active-low reset, clears every register
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr1 - read address, port 1;  rdata1 - read data, port 1
//   raddr2 - read address, port 2;  rdata2 - read data, port 2
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data to matching reads.
module reg_file #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata2
);

    // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] regs [DEPTH-1:1];
    logic             wr_ok;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && ({1'b0, a} < DEPTH_LIM);
    endfunction

    assign wr_ok = we && addr_ok(waddr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            regs <= '{default: '0};
        else if (wr_ok)
            regs[waddr] <= wdata;
    end

    function automatic logic [WIDTH-1:0] rd(input logic [AW-1:0] a);
`ifdef REGFILE_BYPASS_EN
        if (reset && wr_ok && a == waddr)
            return wdata;
`endif
        return (reset && addr_ok(a)) ? regs[a] : '0;
    endfunction

    assign rdata1 = rd(raddr1);
    assign rdata2 = rd(raddr2);

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: randomized and directed checks of reg_file against an array-based reference model.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  waddr, raddr1, raddr2;
    logic [31:0] wdata, rdata1, rdata2;

    logic        s_we;
    logic [3:0]  s_waddr, s_raddr1, s_raddr2;
    logic [15:0] s_wdata, s_rdata1, s_rdata2;

    logic [31:0] m  [32];
    logic [15:0] sm [12];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    reg_file dut (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .rdata1(rdata1), .raddr2(raddr2), .rdata2(rdata2)
    );

    reg_file #(.WIDTH(16), .DEPTH(12)) dut_s (
        .clk(clk), .reset(reset), .we(s_we), .waddr(s_waddr), .wdata(s_wdata),
        .raddr1(s_raddr1), .rdata1(s_rdata1), .raddr2(s_raddr2), .rdata2(s_rdata2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_main(input logic [4:0] a);
        if (!reset || a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we && waddr == a) return wdata;
`endif
        return m[a];
    endfunction

    function automatic logic [15:0] exp_small(input logic [3:0] a);
        if (!reset || a == 0 || a >= 12) return 16'h0;
`ifdef REGFILE_BYPASS_EN
        if (s_we && s_waddr == a) return s_wdata;
`endif
        return sm[a];
    endfunction

    // Advance one rising edge and apply the architectural write rules to the models.
    task automatic tick();
        @(posedge clk);
        if (reset && we && waddr != 0) m[waddr] = wdata;
        if (reset && s_we && s_waddr != 0 && s_waddr < 12) sm[s_waddr] = s_wdata;
        #1;
    endtask

    task automatic clear_models();
        foreach (m[i]) m[i] = '0;
        foreach (sm[i]) sm[i] = '0;
    endtask

    task automatic wr_main(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic wr_small(input logic [3:0] a, input logic [15:0] d);
        s_we = 1'b1; s_waddr = a; s_wdata = d;
        tick();
        s_we = 1'b0;
    endtask

    task automatic rd_main(input string tag, input logic [4:0] a1, input logic [4:0] a2);
        raddr1 = a1; raddr2 = a2;
        #1;
        check({tag, "_p1"}, 64'(rdata1), 64'(exp_main(a1)));
        check({tag, "_p2"}, 64'(rdata2), 64'(exp_main(a2)));
    endtask

    initial begin
        reset = 1'b0;
        we = 0; waddr = 0; wdata = 0; raddr1 = 0; raddr2 = 0;
        s_we = 0; s_waddr = 0; s_wdata = 0; s_raddr1 = 0; s_raddr2 = 0;
        clear_models();
        #12;
        rd_main("reset_init", 5'd1, 5'd31);
        reset = 1'b1;

        // Fill and then reset mid-cycle: reads must drop to zero before any clock edge.
        for (int a = 1; a < 32; a++) wr_main(5'(a), 32'hFFFF_FFFF);
        rd_main("filled", 5'd1, 5'd31);
        #2;
        reset = 1'b0;
        clear_models();
        #1;
        for (int a = 0; a < 32; a++) rd_main("async_reset", 5'(a), 5'(31 - a));
        wr_main(5'd9, 32'h9999_9999);
        rd_main("write_in_reset", 5'd9, 5'd9);
        #2 reset = 1'b1;

        // Reset coincident with a write wins; the first edge after release writes normally.
        wr_main(5'd3, 32'h3333_3333);
        rd_main("pre_reset_w3", 5'd3, 5'd0);
        we = 1; waddr = 5'd3; wdata = 32'hA5A5_A5A5; reset = 1'b0;
        clear_models();
        tick();
        we = 0;
        #2 reset = 1'b1;
        rd_main("reset_vs_write", 5'd3, 5'd3);
        wr_main(5'd4, 32'h4444_4444);
        rd_main("first_edge_write", 5'd4, 5'd3);

        wr_main(5'd5, 32'hDEAD_BEEF);
        rd_main("wr_rd_5", 5'd5, 5'd5);
        rd_main("rd_6", 5'd6, 5'd5);
        check("dead_const", 64'(rdata2), 64'h0000_0000_DEAD_BEEF);

        wr_main(5'd0, 32'h1234_5678);
        rd_main("zero_reg", 5'd0, 5'd0);
        check("zero_const", 64'(rdata1), 64'h0);

        wr_main(5'd7, 32'h1111_1111);
        we = 1; waddr = 5'd7; wdata = 32'h2222_2222;
        rd_main("bypass_same_cycle", 5'd7, 5'd7);
`ifdef REGFILE_BYPASS_EN
        check("bypass_const", 64'(rdata1), 64'h2222_2222);
`else
        check("bypass_const", 64'(rdata1), 64'h1111_1111);
`endif
        tick();
        we = 0;
        rd_main("bypass_after_edge", 5'd7, 5'd0);
        check("after_edge_const", 64'(rdata1), 64'h2222_2222);

        we = 1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        rd_main("bypass_addr0", 5'd0, 5'd0);
        tick();
        we = 0;

        // Back-to-back writes to one address keep the last value.
        we = 1; waddr = 5'd12; wdata = 32'hAAAA_0001;
        tick();
        wdata = 32'hAAAA_0002;
        tick();
        we = 0;
        rd_main("back_to_back", 5'd12, 5'd12);

        // Small configuration: out-of-range write discarded, out-of-range read zero.
        wr_small(4'd11, 16'hBEEF);
        wr_small(4'd13, 16'h1357);
        for (int a = 0; a < 16; a++) begin
            s_raddr1 = 4'(a); s_raddr2 = 4'(15 - a);
            #1;
            check("small_p1", 64'(s_rdata1), 64'(exp_small(4'(a))));
            check("small_p2", 64'(s_rdata2), 64'(exp_small(4'(15 - a))));
        end
        s_raddr1 = 4'd11; s_raddr2 = 4'd13;
        #1;
        check("small_11_const", 64'(s_rdata1), 64'hBEEF);
        check("small_13_const", 64'(s_rdata2), 64'h0);

        // Random traffic on both instances, reads checked before each edge.
        for (int i = 0; i < 600; i++) begin
            we = 1'($urandom_range(0, 1));
            waddr = 5'($urandom_range(0, 31));
            wdata = $urandom;
            s_we = 1'($urandom_range(0, 1));
            s_waddr = 4'($urandom_range(0, 15));
            s_wdata = 16'($urandom);
            s_raddr1 = ($urandom_range(0, 3) == 0) ? s_waddr : 4'($urandom_range(0, 15));
            s_raddr2 = 4'($urandom_range(0, 15));
            rd_main("rand", ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)));
            check("rand_s1", 64'(s_rdata1), 64'(exp_small(s_raddr1)));
            check("rand_s2", 64'(s_rdata2), 64'(exp_small(s_raddr2)));
            tick();
        end
        we = 0; s_we = 0;
        for (int a = 0; a < 32; a++) rd_main("final", 5'(a), 5'(a));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
